writeback_unit: RTL
===================

# writeback_unit

Final pipeline stage of the RV32I core. Accepts retiring instructions from the memory stage over a valid/ready handshake and selects the result (ALU, load data, PC+4). Aligns and sign/zero-extends load data returned by the synchronous data memory, then drives the register bank write port (rd_addr, rd_we, rd_data_from_wb). Also counts retired instructions and flags misaligned loads.

## Interface
- XLEN, 32: datapath width.
- REG_AW, 5: register address width.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- mem_valid  in  1  memory stage presents an instruction.
- mem_ready  out  1  writeback can accept.
- mem_rd_addr  in  REG_AW  destination register.
- mem_rd_en  in  1  instruction writes rd.
- mem_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (no write).
- mem_alu_result  in  XLEN  ALU result; for loads, the effective address.
- mem_pc_plus4  in  XLEN  link value.
- mem_funct3  in  3  load size/sign.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  raw aligned word from data memory.
- rd_addr  out  REG_AW  register bank write address.
- rd_we  out  1  register bank write enable.
- rd_data_from_wb  out  XLEN  register bank write data.
- load_misaligned  out  1  one-cycle pulse on a misaligned or illegal load.
- instret  out  64  retired-instruction counter.

## Operation
- FSM states: ACCEPT, LOAD_WAIT. Reset state is ACCEPT.
- ACCEPT:
  - mem_ready = 1.
  - A handshake (mem_valid & mem_ready) with wb_sel 00, 10, or 11 registers the write outputs next cycle.
  - A handshake with wb_sel 01 and a legal, aligned load latches rd, funct3, and addr[1:0], then goes to LOAD_WAIT.
- LOAD_WAIT:
  - mem_ready = 0.
  - On dmem_rvalid, extract and extend the data, register the write outputs, and return to ACCEPT.
- Load extraction:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - funct3 000 LB sign-extends, 100 LBU zero-extends, 001 LH sign-extends, 101 LHU zero-extends, 010 LW passes through.
- Misaligned or illegal load:
  - Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]≠0. Illegal means funct3 011, 110, or 111.
  - No write and no LOAD_WAIT entry.
  - load_misaligned pulses for one cycle, the cycle after the handshake.
  - instret is not incremented.
- rd_we = registered (mem_rd_en & wb_sel≠11 & rd≠0). Writes to x0 are always suppressed, but the instruction still retires.
- instret increments by 1 in the same cycle rd_we would be asserted, whether or not the write is suppressed; it wraps modulo 2^64.
- dmem_rvalid in ACCEPT is ignored.

## Timing
- Reset values: mem_ready=1 (after reset deasserts), rd_we=0, rd_addr=0, rd_data_from_wb=0, load_misaligned=0, instret=0, state ACCEPT.
- Non-load: handshake at cycle N gives rd_we=1 at cycle N+1 for exactly one cycle; back-to-back throughput is 1 per cycle.
- Load: handshake at N; mem_ready=0 from N+1; dmem_rvalid at M (M ≥ N+1) gives rd_we=1 at M+1; mem_ready=1 at M+1, so a new handshake is possible at M+1.
- rd_we is high for one cycle per write; rd_addr and rd_data_from_wb are don't-care when rd_we=0 but hold their last values.
- Reset asserted mid-LOAD_WAIT: the pending load is dropped, with no write and no retire. A dmem_rvalid in the reset cycle is ignored.
- All outputs are registered; there is no combinational path from mem_* to rd_*. mem_ready depends only on state.

## Structure
- Shared package core_pkg holds:
  - WB_SEL_ALU/LOAD/PC4/NONE encodings.
  - F3_LB/LH/LW/LBU/LHU constants.
  - XLEN and REG_AW defaults.
- Sub-module load_align: purely combinational (raw word, addr[1:0], funct3) -> extended data plus misaligned/illegal flag. The memory stage reuses its flag for store checks.
- The FSM, output registers, and instret counter live in writeback_unit.

## Test plan
- ALU writes: rd=5 with 0xDEADBEEF, then rd=6 with 0x1 on consecutive cycles -> rd_we high two consecutive cycles with matching addr/data; instret=2.
- Write to x0: wb_sel=00, rd=0, data 0x1234 -> rd_we stays 0; instret increments by 1.
- Load extension: dmem_rdata=0x80FF7F01, rvalid 3 cycles after accept:
  - LB addr 0x3 -> 0xFFFFFF80.
  - LBU addr 0x1 -> 0x0000007F.
  - LH addr 0x2 -> 0xFFFF80FF.
  - LW addr 0x0 -> 0x80FF7F01.
  - In each case rd_we fires the cycle after rvalid, and mem_ready is low in between.
- Misaligned LW at addr 0x102 -> load_misaligned pulses once, rd_we never asserts, mem_ready stays 1, instret unchanged.
- Reset during LOAD_WAIT (LW to rd=7, reset asserted before rvalid, rvalid in the same cycle) -> no write to rd=7, instret=0, mem_ready=1 after reset.
- PC+4 select: wb_sel=10, pc_plus4=0x00000104, rd=1 -> rd_data_from_wb=0x104. A following wb_sel=11 gives no write.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core constants: writeback select encodings, load funct3 codes,
// datapath defaults and the writeback FSM state type.
package core_pkg;

  localparam int DEFAULT_XLEN   = 32;
  localparam int DEFAULT_REG_AW = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_NONE = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_ACCEPT    = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction and sign/zero extension. The fault flag
// depends only on addr/funct3, so the memory stage can reuse it for stores.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            fault
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes of the raw word.
  always_comb begin
    byte_s = raw[7:0];
    half_s = raw[15:0];
    case (addr)
      2'b00:   byte_s = raw[7:0];
      2'b01:   byte_s = raw[15:8];
      2'b10:   byte_s = raw[23:16];
      2'b11:   byte_s = raw[31:24];
      default: byte_s = raw[7:0];
    endcase
    if (addr[1]) begin
      half_s = raw[31:16];
    end else begin
      half_s = raw[15:0];
    end
  end

  // Extend per load size; unknown funct3 values are illegal.
  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH: begin
        data  = {{(XLEN-16){half_s[15]}}, half_s};
        fault = addr[0];
      end
      F3_LHU: begin
        data  = {{(XLEN-16){1'b0}}, half_s};
        fault = addr[0];
      end
      F3_LW: begin
        data  = raw;
        fault = (addr != 2'b00);
      end
      default: begin
        data  = '0;
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// RV32I writeback stage: result select, load completion FSM, register bank
// write port, retired-instruction counter and misaligned-load pulse.
module writeback_unit
  import core_pkg::*;
#(
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int REG_AW = DEFAULT_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_en,
  input  logic [1:0]        mem_wb_sel,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [XLEN-1:0]   mem_pc_plus4,
  input  logic [2:0]        mem_funct3,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [REG_AW-1:0] rd_addr,
  output logic              rd_we,
  output logic [XLEN-1:0]   rd_data_from_wb,
  output logic              load_misaligned,
  output logic [63:0]       instret
);

  wb_state_e         state_r, next_state_s;
  logic [REG_AW-1:0] ld_rd_r;
  logic              ld_rd_en_r;
  logic [2:0]        ld_funct3_r;
  logic [1:0]        ld_addr_r;

  logic [REG_AW-1:0] rd_addr_r;
  logic              rd_we_r;
  logic [XLEN-1:0]   rd_data_r;
  logic              load_misaligned_r;
  logic [63:0]       instret_r;

  logic [1:0]        align_addr_s;
  logic [2:0]        align_funct3_s;
  logic [XLEN-1:0]   align_data_s;
  logic              align_fault_s;

  logic              retire_s;
  logic              wr_en_s;
  logic [REG_AW-1:0] wr_addr_s;
  logic [XLEN-1:0]   wr_data_s;
  logic              misalign_s;
  logic              latch_load_s;

  // Fault check uses the live request in ACCEPT, extraction uses the latched load.
  always_comb begin
    if (state_r == ST_ACCEPT) begin
      align_addr_s   = mem_alu_result[1:0];
      align_funct3_s = mem_funct3;
    end else begin
      align_addr_s   = ld_addr_r;
      align_funct3_s = ld_funct3_r;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .raw    (dmem_rdata),
    .addr   (align_addr_s),
    .funct3 (align_funct3_s),
    .data   (align_data_s),
    .fault  (align_fault_s)
  );

  assign mem_ready = (state_r == ST_ACCEPT);

  // Next-state and next-write decode.
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    wr_en_s      = 1'b0;
    wr_addr_s    = rd_addr_r;
    wr_data_s    = rd_data_r;
    misalign_s   = 1'b0;
    latch_load_s = 1'b0;
    case (state_r)
      ST_ACCEPT: begin
        if (mem_valid) begin
          if (mem_wb_sel == WB_SEL_LOAD) begin
            if (align_fault_s) begin
              misalign_s = 1'b1;
            end else begin
              latch_load_s = 1'b1;
              next_state_s = ST_LOAD_WAIT;
            end
          end else begin
            retire_s  = 1'b1;
            wr_en_s   = mem_rd_en && (mem_wb_sel != WB_SEL_NONE) &&
                        (mem_rd_addr != {REG_AW{1'b0}});
            wr_addr_s = mem_rd_addr;
            if (mem_wb_sel == WB_SEL_PC4) begin
              wr_data_s = mem_pc_plus4;
            end else begin
              wr_data_s = mem_alu_result;
            end
          end
        end else begin
          next_state_s = ST_ACCEPT;
        end
      end
      ST_LOAD_WAIT: begin
        if (dmem_rvalid) begin
          retire_s     = 1'b1;
          wr_en_s      = ld_rd_en_r && (ld_rd_r != {REG_AW{1'b0}});
          wr_addr_s    = ld_rd_r;
          wr_data_s    = align_data_s;
          next_state_s = ST_ACCEPT;
        end else begin
          next_state_s = ST_LOAD_WAIT;
        end
      end
      default: next_state_s = ST_ACCEPT;
    endcase
  end

  // State, pending-load context, write port and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= ST_ACCEPT;
      ld_rd_r           <= {REG_AW{1'b0}};
      ld_rd_en_r        <= 1'b0;
      ld_funct3_r       <= 3'b000;
      ld_addr_r         <= 2'b00;
      rd_addr_r         <= {REG_AW{1'b0}};
      rd_we_r           <= 1'b0;
      rd_data_r         <= {XLEN{1'b0}};
      load_misaligned_r <= 1'b0;
      instret_r         <= 64'd0;
    end else begin
      state_r           <= next_state_s;
      rd_we_r           <= wr_en_s;
      rd_addr_r         <= wr_addr_s;
      rd_data_r         <= wr_data_s;
      load_misaligned_r <= misalign_s;
      if (retire_s) begin
        instret_r <= instret_r + 64'd1;
      end
      if (latch_load_s) begin
        ld_rd_r     <= mem_rd_addr;
        ld_rd_en_r  <= mem_rd_en;
        ld_funct3_r <= mem_funct3;
        ld_addr_r   <= mem_alu_result[1:0];
      end
    end
  end

  assign rd_addr         = rd_addr_r;
  assign rd_we           = rd_we_r;
  assign rd_data_from_wb = rd_data_r;
  assign load_misaligned = load_misaligned_r;
  assign instret         = instret_r;

endmodule
